rot_dma_sequencer: RTL and testbench
====================================

Name: rot_dma_sequencer

Overview:
Tile-level controller for the rotation engine's DMA path. On start it walks the input image in 4x4-pixel tiles (1 pixel = 1 byte, 4 pixels = 1 32-bit word). For each tile it issues 4 word-read commands and then 4 word-write commands to the AHB master through a valid/ready command port. Write addresses place each rotated tile at its destination tile position. It sits between the APB register block (config/start) and the AHB DMA master; the tile buffer performs the in-tile pixel rotation using O_ROT.

Parameters:
ADDR_W, 32, byte address width of source/destination/command address
H_W, 15, input height width (max 32767)
W_W, 14, input width width (max 16383)

Ports:
I_HCLK  in  1  clock; all logic on rising edge
I_HRESET  in  1  synchronous active-high reset
I_START  in  1  single-cycle start pulse from register block
I_SRC_ADDR  in  ADDR_W  input image base (byte, word-aligned)
I_DST_ADDR  in  ADDR_W  output image base (byte, word-aligned)
I_HEIGHT  in  H_W  input height in pixels
I_WIDTH  in  W_W  input width in pixels
I_MODE  in  2  0/90/180/270 degrees
I_DIR  in  1  0=cw, 1=ccw
I_CMD_READY  in  1  DMA accepts command
O_CMD_VALID  out  1  command valid
O_CMD_WRITE  out  1  1=write, 0=read
O_CMD_ADDR  out  ADDR_W  word byte address
O_ROT  out  2  effective cw rotation of current job
O_BUSY  out  1  job in progress
O_DONE  out  1  one-cycle completion pulse
O_STALL_CNT  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state IDLE; latched config cleared.
- Config (addresses, dims, effective rotation) latched on I_START in IDLE. Effective rotation R = I_MODE if cw, (4-I_MODE) mod 4 if ccw.
- I_START ignored when not IDLE.
- Padded dims: Wp = ceil(W/4)*4, Hp = ceil(H/4)*4; TW = Wp/4, TH = Hp/4. Destination buffer covers the padded size; padding pixels are written.
- Output stride: Wp bytes for R=0/2, Hp bytes for R=1/3.
- Tile order: tr outer 0..TH-1, tc inner 0..TW-1.
- Read i (0..3) addr = SRC + (tr*4+i)*Wp + tc*4.
- Output tile (otr,otc):
  - R0 = (tr,tc)
  - R1 = (tc, TH-1-tr)
  - R2 = (TH-1-tr, TW-1-tc)
  - R3 = (TW-1-tc, tr)
- Write j addr = DST + (otr*4+j)*stride + otc*4.
- Address arithmetic modulo 2^ADDR_W; products fit in 30 bits. Incremental adders are preferred over multipliers.
- FSM states and transitions:
  - IDLE: on I_START go to RD; if H==0 or W==0, go to FIN instead.
  - RD: 4 read commands, then WR.
  - WR: 4 write commands; then RD for the next tile, or FIN after the last tile.
  - FIN: O_DONE=1 for one cycle, then IDLE.
- Handshake: a command is transferred when O_CMD_VALID & I_CMD_READY. While valid and not ready, O_CMD_WRITE and O_CMD_ADDR are held stable. Valid is never withdrawn before acceptance.
- Timing: O_CMD_VALID asserts the cycle after I_START is sampled. With ready held high, one command per cycle, no bubbles between RD/WR or between tiles. O_DONE is asserted the cycle after the last write is accepted.
- O_BUSY = 1 from the cycle after I_START through the FIN cycle.
- O_ROT valid while busy; holds its last value in IDLE.
- Reset mid-job: immediate return to IDLE; outputs cleared; no O_DONE.

Optional Feature:
ROT_STALL_CNT_EN.
- Defined: O_STALL_CNT counts cycles with O_CMD_VALID & !I_CMD_READY. Cleared on I_START accept and on reset; saturates at 0xFFFFFFFF; holds its value after done.
- Undefined: O_STALL_CNT tied to 0; no counter logic.

Decomposition:
- Package rot_pkg: rotation enum (ROT_0..ROT_270), direction constants (DIR_CW=0, DIR_CCW=1), FSM state enum, TILE_DIM=4, WORD_BYTES=4.
- One sub-module, rot_tile_map: combinational; maps (tr,tc,TH,TW,R) to (otr,otc) and output stride.

Test Plan:
1. H=4, W=4, mode0 cw, SRC=0x1000, DST=0x2000, ready=1 -> reads 0x1000/04/08/0C, then writes 0x2000/04/08/0C on cycles 1-8; O_DONE at cycle 9.
2. H=8, W=4, mode1 cw, SRC=0, DST=0x100 -> tile0: reads 0,4,8,C; writes 0x104,0x10C,0x114,0x11C. Tile1: reads 0x10,0x14,0x18,0x1C; writes 0x100,0x108,0x110,0x118. O_ROT=1.
3. Same dims, mode1 ccw -> O_ROT=3; tile0 writes 0x100,0x108,0x110,0x118; tile1 writes 0x104,0x10C,0x114,0x11C.
4. H=5, W=6 mode2 cw -> Wp=8, Hp=8; 4 tiles, 32 commands. First write addr DST+0x24 (tile(0,0) -> out tile (1,1)); O_DONE after 32nd accept.
5. I_CMD_READY low 3 cycles on the 2nd read -> addr/write held constant; total job 3 cycles longer; O_STALL_CNT=3 with ROT_STALL_CNT_EN, 0 without.
6. H=0 start -> no O_CMD_VALID, O_DONE next cycle. Second I_START while busy -> ignored. I_HRESET during WR -> outputs 0 next cycle, no O_DONE.

Source files
------------

// File: rtl/rot_dma_sequencer_pkg.sv
// Shared types and constants for the rotation DMA tile sequencer.
// Holds the rotation/state enums, direction codes and tile geometry.
package rot_pkg;

    localparam int TILE_DIM   = 4;
    localparam int WORD_BYTES = 4;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rot_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // A ccw turn by m quarters equals a cw turn by (4-m) mod 4 quarters,
    // which is simply -m in 2-bit arithmetic.
    function automatic rot_e eff_rot(input logic [1:0] mode,
                                     input logic       dir);
        if (dir == DIR_CCW) begin
            return rot_e'(2'd0 - mode);
        end
        return rot_e'(mode);
    endfunction

endpackage

// File: rtl/rot_dma_sequencer_if.sv
// Command port between the tile sequencer and the AHB DMA master.
// master: drives O_CMD_VALID/O_CMD_WRITE/O_CMD_ADDR, samples I_CMD_READY.
interface rot_dma_sequencer_if #(
    parameter int ADDR_W = 32
) ();

    logic              O_CMD_VALID;
    logic              O_CMD_WRITE;
    logic [ADDR_W-1:0] O_CMD_ADDR;
    logic              I_CMD_READY;

    modport master (
        output O_CMD_VALID,
        output O_CMD_WRITE,
        output O_CMD_ADDR,
        input  I_CMD_READY
    );

    modport slave (
        input  O_CMD_VALID,
        input  O_CMD_WRITE,
        input  O_CMD_ADDR,
        output I_CMD_READY
    );

endinterface

// File: rtl/rot_dma_sequencer_tile_map.sv
// Combinational map from source tile (tr,tc) to destination tile (otr,otc).
// Ports: tr/tc/th/tw/wp/hp + rotation in; otr/otc and output stride out.
module rot_tile_map
    import rot_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] tr_i,
    input  logic [AW-1:0] tc_i,
    input  logic [AW-1:0] th_i,
    input  logic [AW-1:0] tw_i,
    input  logic [AW-1:0] wp_i,
    input  logic [AW-1:0] hp_i,
    input  rot_e          rot_i,
    output logic [AW-1:0] otr_o,
    output logic [AW-1:0] otc_o,
    output logic [AW-1:0] stride_o
);

    logic [AW-1:0] tr_rev;
    logic [AW-1:0] tc_rev;

    assign tr_rev = th_i - tr_i - AW'(1);
    assign tc_rev = tw_i - tc_i - AW'(1);

    always_comb begin
        otr_o    = tr_i;
        otc_o    = tc_i;
        stride_o = wp_i;
        unique case (rot_i)
            ROT_0: begin
                otr_o = tr_i;
                otc_o = tc_i;
            end
            ROT_90: begin
                otr_o    = tc_i;
                otc_o    = tr_rev;
                stride_o = hp_i;
            end
            ROT_180: begin
                otr_o = tr_rev;
                otc_o = tc_rev;
            end
            ROT_270: begin
                otr_o    = tc_rev;
                otc_o    = tr_i;
                stride_o = hp_i;
            end
        endcase
    end

endmodule

// File: rtl/rot_dma_sequencer.sv
// Tile sequencer: walks the image in 4x4 tiles issuing 4 reads + 4 writes.
// Ports: I_HCLK/I_HRESET, start+config in, cmd (master) command port,
// O_ROT/O_BUSY/O_DONE status, O_STALL_CNT (live only with ROT_STALL_CNT_EN).
module rot_dma_sequencer
    import rot_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int H_W    = 15,
    parameter int W_W    = 14
) (
    input  logic              I_HCLK,
    input  logic              I_HRESET,
    input  logic              I_START,
    input  logic [ADDR_W-1:0] I_SRC_ADDR,
    input  logic [ADDR_W-1:0] I_DST_ADDR,
    input  logic [H_W-1:0]    I_HEIGHT,
    input  logic [W_W-1:0]    I_WIDTH,
    input  logic [1:0]        I_MODE,
    input  logic              I_DIR,
    rot_dma_sequencer_if.master cmd,
    output logic [1:0]        O_ROT,
    output logic              O_BUSY,
    output logic              O_DONE,
    output logic [31:0]       O_STALL_CNT
);

    state_e            state_q;
    rot_e              rot_q;
    logic              valid_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q;
    logic              done_q;
    logic [1:0]        idx_q;
    logic [ADDR_W-1:0] tr_q;
    logic [ADDR_W-1:0] tc_q;
    logic [ADDR_W-1:0] th_q;
    logic [ADDR_W-1:0] tw_q;
    logic [ADDR_W-1:0] wp_q;
    logic [ADDR_W-1:0] hp_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] tile_base_q;
    logic [ADDR_W-1:0] row_base_q;

    // Tile counts rounded up so the padding columns/rows get tiles too.
    logic [W_W:0]      w_pad3;
    logic [H_W:0]      h_pad3;
    logic [ADDR_W-1:0] tw_in;
    logic [ADDR_W-1:0] th_in;

    assign w_pad3 = {1'b0, I_WIDTH} + (W_W + 1)'(3);
    assign h_pad3 = {1'b0, I_HEIGHT} + (H_W + 1)'(3);
    assign tw_in  = ADDR_W'(w_pad3 >> 2);
    assign th_in  = ADDR_W'(h_pad3 >> 2);

    logic [ADDR_W-1:0] otr;
    logic [ADDR_W-1:0] otc;
    logic [ADDR_W-1:0] stride;

    rot_tile_map #(
        .AW (ADDR_W)
    ) u_map (
        .tr_i     (tr_q),
        .tc_i     (tc_q),
        .th_i     (th_q),
        .tw_i     (tw_q),
        .wp_i     (wp_q),
        .hp_i     (hp_q),
        .rot_i    (rot_q),
        .otr_o    (otr),
        .otc_o    (otc),
        .stride_o (stride)
    );

    logic [ADDR_W-1:0] wr_base;
    logic [ADDR_W-1:0] row_step;
    logic [ADDR_W-1:0] next_tile;
    logic [ADDR_W-1:0] next_row;
    logic              last_col;
    logic              last_tile;
    logic              accept;

    // Only one multiply per tile: the destination tile origin.
    assign wr_base   = dst_q + ((otr << 2) * stride) + (otc << 2);
    assign row_step  = wp_q * ADDR_W'(TILE_DIM);
    assign next_tile = tile_base_q + ADDR_W'(WORD_BYTES);
    assign next_row  = row_base_q + row_step;
    assign last_col  = (tc_q == tw_q - ADDR_W'(1));
    assign last_tile = last_col && (tr_q == th_q - ADDR_W'(1));
    assign accept    = valid_q && cmd.I_CMD_READY;

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            state_q     <= ST_IDLE;
            rot_q       <= ROT_0;
            valid_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            idx_q       <= '0;
            tr_q        <= '0;
            tc_q        <= '0;
            th_q        <= '0;
            tw_q        <= '0;
            wp_q        <= '0;
            hp_q        <= '0;
            dst_q       <= '0;
            tile_base_q <= '0;
            row_base_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (I_START) begin
                        rot_q       <= eff_rot(I_MODE, I_DIR);
                        busy_q      <= 1'b1;
                        th_q        <= th_in;
                        tw_q        <= tw_in;
                        wp_q        <= tw_in << 2;
                        hp_q        <= th_in << 2;
                        dst_q       <= I_DST_ADDR;
                        tile_base_q <= I_SRC_ADDR;
                        row_base_q  <= I_SRC_ADDR;
                        tr_q        <= '0;
                        tc_q        <= '0;
                        idx_q       <= '0;
                        if (I_HEIGHT == '0 || I_WIDTH == '0) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RD;
                            valid_q <= 1'b1;
                            write_q <= 1'b0;
                            addr_q  <= I_SRC_ADDR;
                        end
                    end
                end
                ST_RD: begin
                    if (accept) begin
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= ST_WR;
                            write_q <= 1'b1;
                            addr_q  <= wr_base;
                        end else begin
                            addr_q <= addr_q + wp_q;
                        end
                    end
                end
                ST_WR: begin
                    if (accept) begin
                        idx_q <= idx_q + 2'd1;
                        if (idx_q != 2'd3) begin
                            addr_q <= addr_q + stride;
                        end else if (last_tile) begin
                            state_q <= ST_FIN;
                            valid_q <= 1'b0;
                            write_q <= 1'b0;
                            addr_q  <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RD;
                            write_q <= 1'b0;
                            if (last_col) begin
                                tc_q        <= '0;
                                tr_q        <= tr_q + ADDR_W'(1);
                                row_base_q  <= next_row;
                                tile_base_q <= next_row;
                                addr_q      <= next_row;
                            end else begin
                                tc_q        <= tc_q + ADDR_W'(1);
                                tile_base_q <= next_tile;
                                addr_q      <= next_tile;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd.O_CMD_VALID = valid_q;
    assign cmd.O_CMD_WRITE = write_q;
    assign cmd.O_CMD_ADDR  = addr_q;
    assign O_ROT           = rot_q;
    assign O_BUSY          = busy_q;
    assign O_DONE          = done_q;

`ifdef ROT_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            stall_q <= '0;
        end else if (state_q == ST_IDLE && I_START) begin
            stall_q <= '0;
        end else if (valid_q && !cmd.I_CMD_READY && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign O_STALL_CNT = stall_q;
`else
    assign O_STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_rot_dma_sequencer.sv
// Scoreboard bench for rot_dma_sequencer: expected commands are queued
// from an address model at start and popped on every accepted command.
module tb_rot_dma_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [14:0] h = '0;
    logic [13:0] w = '0;
    logic [1:0]  mode = '0;
    logic        dir = 1'b0;
    logic [1:0]  rot;
    logic        busy;
    logic        done;
    logic [31:0] stall;

    rot_dma_sequencer_if #(.ADDR_W(32)) cmd_if ();

    always #5 clk = ~clk;

    rot_dma_sequencer #(
        .ADDR_W (32),
        .H_W    (15),
        .W_W    (14)
    ) dut (
        .I_HCLK      (clk),
        .I_HRESET    (rst),
        .I_START     (start),
        .I_SRC_ADDR  (src),
        .I_DST_ADDR  (dst),
        .I_HEIGHT    (h),
        .I_WIDTH     (w),
        .I_MODE      (mode),
        .I_DIR       (dir),
        .cmd         (cmd_if),
        .O_ROT       (rot),
        .O_BUSY      (busy),
        .O_DONE      (done),
        .O_STALL_CNT (stall)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [32:0] exp_q[$];

`ifdef ROT_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    task automatic model(input int hh, input int ww, input int md,
                         input int dr, input logic [31:0] s,
                         input logic [31:0] d);
        int tw, th, wp, hp, r, strd, otr, otc;
        tw = (ww + 3) / 4;
        th = (hh + 3) / 4;
        wp = tw * 4;
        hp = th * 4;
        r = (dr != 0) ? (4 - md) % 4 : md;
        strd = (r % 2 == 0) ? wp : hp;
        for (int tr = 0; tr < th; tr++) begin
            for (int tc = 0; tc < tw; tc++) begin
                for (int i = 0; i < 4; i++)
                    exp_q.push_back({1'b0, s + 32'((tr * 4 + i) * wp + tc * 4)});
                case (r)
                    0: begin otr = tr; otc = tc; end
                    1: begin otr = tc; otc = th - 1 - tr; end
                    2: begin otr = th - 1 - tr; otc = tw - 1 - tc; end
                    default: begin otr = tw - 1 - tc; otc = tr; end
                endcase
                for (int j = 0; j < 4; j++)
                    exp_q.push_back({1'b1, d + 32'((otr * 4 + j) * strd + otc * 4)});
            end
        end
    endtask

    task automatic run_job(input string tag, input int hh, input int ww,
                           input int md, input int dr,
                           input logic [31:0] s, input logic [31:0] d,
                           input int st_idx, input int st_len,
                           input bit extra_start,
                           output logic [31:0] first_wr);
        int ncmd, cyc, acc, left, exp_rot, exp_cyc;
        bit got_done, holding, fw_seen;
        logic [32:0] e, held, obs;
        exp_q.delete();
        model(hh, ww, md, dr, s, d);
        ncmd = exp_q.size();
        exp_rot = (dr != 0) ? (4 - md) % 4 : md;
        exp_cyc = ncmd + st_len + 1;
        first_wr = '0;
        fw_seen = 1'b0;
        h = 15'(hh);
        w = 14'(ww);
        mode = 2'(md);
        dir = 1'(dr);
        src = s;
        dst = d;
        cmd_if.I_CMD_READY = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        acc = 0;
        left = st_len;
        got_done = 1'b0;
        holding = 1'b0;
        held = '0;
        while (!got_done && cyc < 400) begin
            if (extra_start && cyc == 3) begin
                start = 1'b1;
                src = 32'hDEAD_0000;
                h = '0;
            end
            if (extra_start && cyc == 4) begin
                start = 1'b0;
                src = s;
                h = 15'(hh);
            end
            obs = {cmd_if.O_CMD_WRITE, cmd_if.O_CMD_ADDR};
            if (done) begin
                got_done = 1'b1;
                n_cmp++;
                if (cyc !== exp_cyc) begin
                    n_bad++;
                    $display("FAIL %s done_cycle got=%0d want=%0d", tag, cyc, exp_cyc);
                end
                n_cmp++;
                if (exp_q.size() != 0 || cmd_if.O_CMD_VALID !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s done_early left=%0d valid=%b want 0/0",
                             tag, exp_q.size(), cmd_if.O_CMD_VALID);
                end
            end else begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s busy cyc=%0d got=%b want=1", tag, cyc, busy);
                end
                if (holding) begin
                    n_cmp++;
                    if (obs !== held) begin
                        n_bad++;
                        $display("FAIL %s stall_hold got=%h want=%h", tag, obs, held);
                    end
                end
                if (cmd_if.O_CMD_VALID === 1'b1) begin
                    if (acc == st_idx && left > 0) begin
                        cmd_if.I_CMD_READY = 1'b0;
                        left--;
                        holding = 1'b1;
                        held = obs;
                    end else begin
                        cmd_if.I_CMD_READY = 1'b1;
                        holding = 1'b0;
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_bad++;
                            $display("FAIL %s extra_cmd got=%h want=none", tag, obs);
                        end else begin
                            e = exp_q.pop_front();
                            if (obs !== e) begin
                                n_bad++;
                                $display("FAIL %s cmd%0d got=%h want=%h", tag, acc, obs, e);
                            end
                        end
                        if (obs[32] && !fw_seen) begin
                            fw_seen = 1'b1;
                            first_wr = obs[31:0];
                        end
                        acc++;
                    end
                end else begin
                    cmd_if.I_CMD_READY = 1'b1;
                    holding = 1'b0;
                    if (acc < ncmd) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL %s bubble cyc=%0d got=0 want=1", tag, cyc);
                    end
                end
            end
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        cmd_if.I_CMD_READY = 1'b1;
        if (!got_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout got=no_done want=done", tag);
        end
        n_cmp++;
        if (rot !== 2'(exp_rot)) begin
            n_bad++;
            $display("FAIL %s rot got=%0d want=%0d", tag, rot, exp_rot);
        end
        n_cmp++;
        if (stall !== (STALL_EN ? 32'(st_len) : 32'd0)) begin
            n_bad++;
            $display("FAIL %s stall_cnt got=%0d want=%0d", tag, stall,
                     STALL_EN ? st_len : 0);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || rot !== 2'(exp_rot)) begin
            n_bad++;
            $display("FAIL %s idle busy/done/rot got=%b/%b/%0d want=0/0/%0d",
                     tag, busy, done, rot, exp_rot);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_if.I_CMD_READY = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cmd_if.O_CMD_VALID, cmd_if.O_CMD_WRITE, cmd_if.O_CMD_ADDR,
             rot, busy, done, stall} !== '0) begin
            n_bad++;
            $display("FAIL reset got v=%b w=%b a=%h rot=%0d b=%b d=%b s=%0d want all 0",
                     cmd_if.O_CMD_VALID, cmd_if.O_CMD_WRITE, cmd_if.O_CMD_ADDR,
                     rot, busy, done, stall);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_first(input string tag, input logic [31:0] got,
                               input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s first_write got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic test_basic();
        logic [31:0] fw;
        run_job("basic", 4, 4, 0, 0, 32'h1000, 32'h2000, -1, 0, 1'b0, fw);
        check_first("basic", fw, 32'h2000);
    endtask

    task automatic test_rot90();
        logic [31:0] fw;
        run_job("rot90cw", 8, 4, 1, 0, 32'h0, 32'h100, -1, 0, 1'b0, fw);
        check_first("rot90cw", fw, 32'h104);
        run_job("rot90ccw", 8, 4, 1, 1, 32'h0, 32'h100, -1, 0, 1'b0, fw);
        check_first("rot90ccw", fw, 32'h100);
    endtask

    task automatic test_pad_rot180();
        logic [31:0] fw;
        run_job("pad180", 5, 6, 2, 0, 32'h4000, 32'h8000, -1, 0, 1'b0, fw);
        check_first("pad180", fw, 32'h8024);
        run_job("rot270", 8, 12, 3, 0, 32'h400, 32'h900, -1, 0, 1'b0, fw);
        run_job("ccw270", 9, 3, 3, 1, 32'h40, 32'h3000, -1, 0, 1'b0, fw);
    endtask

    task automatic test_stall();
        logic [31:0] fw;
        run_job("stall", 4, 4, 0, 0, 32'h1000, 32'h2000, 1, 3, 1'b0, fw);
        run_job("stall_clr", 4, 8, 2, 1, 32'h0, 32'h500, -1, 0, 1'b0, fw);
    endtask

    task automatic test_zero_dim();
        logic [31:0] fw;
        run_job("h_zero", 0, 8, 1, 0, 32'h100, 32'h200, -1, 0, 1'b0, fw);
        run_job("w_zero", 8, 0, 0, 0, 32'h100, 32'h200, -1, 0, 1'b0, fw);
    endtask

    task automatic test_busy_start();
        logic [31:0] fw;
        run_job("busy_start", 8, 8, 1, 1, 32'h600, 32'h700, -1, 0, 1'b1, fw);
    endtask

    task automatic test_reset_mid();
        int k;
        bit saw_done;
        h = 15'd4;
        w = 14'd4;
        mode = 2'd1;
        dir = 1'b0;
        src = 32'h1000;
        dst = 32'h2000;
        cmd_if.I_CMD_READY = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(cmd_if.O_CMD_VALID === 1'b1 && cmd_if.O_CMD_WRITE === 1'b1) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rst_mid reach_wr got=timeout want=write");
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cmd_if.O_CMD_VALID, cmd_if.O_CMD_WRITE, cmd_if.O_CMD_ADDR,
             rot, busy, done, stall} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid outputs got v=%b w=%b a=%h rot=%0d b=%b d=%b want all 0",
                     cmd_if.O_CMD_VALID, cmd_if.O_CMD_WRITE, cmd_if.O_CMD_ADDR,
                     rot, busy, done);
        end
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || cmd_if.O_CMD_VALID === 1'b1) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done) begin
            n_bad++;
            $display("FAIL rst_mid after_reset got=activity want=idle");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] fw;
        run_job("b2b_a", 4, 4, 0, 0, 32'h1000, 32'h2000, -1, 0, 1'b0, fw);
        check_first("b2b_a", fw, 32'h2000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rot90();
        test_pad_rot180();
        test_stall();
        test_zero_dim();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
